// File: rtl/demux_1x4_stream_pkg.sv
// demux_1x4_stream_pkg: shared widths and channel constants for the stream demultiplexer
package demux_1x4_stream_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/demux_1x4_stream_dec_2x4_en.sv
// dec_2x4_en: one-hot 2:4 decoder, all outputs low when en is low
module dec_2x4_en
  import demux_1x4_stream_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NUM_CH-1:0] y
);
  // one-hot strobe for the selected channel, gated by enable
  always_comb y = en ? NUM_CH'(1) << sel : '0;
endmodule

// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: steers one valid/ready stream to four registered output channels, dropping beats to disabled channels
module demux_1x4_stream
  import demux_1x4_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [NUM_CH-1:0]        chan_en,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);
  logic [NUM_CH-1:0] dec;
  logic [NUM_CH-1:0] load;
  logic              drop;
  dec_2x4_en u_dec (
    .en  (in_valid),
    .sel (in_sel),
    .y   (dec)
  );
  // pass-through ready: disabled channels always accept, a draining slot accepts too
  always_comb begin
    in_ready = ~chan_en[in_sel] | ~out_valid[in_sel] | out_ready[in_sel];
    load = dec & chan_en & {NUM_CH{in_ready}};
    drop = in_valid & in_ready & ~chan_en[in_sel];
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // one-entry holding stage: load wins over drain, data is kept after drain
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        out_valid[k] <= 1'b0;
        out_data[k*DATA_W +: DATA_W] <= '0;
      end else if (load[k]) begin
        out_valid[k] <= 1'b1;
        out_data[k*DATA_W +: DATA_W] <= in_data;
      end else if (out_ready[k]) out_valid[k] <= 1'b0;
  end
  // saturating count of beats sent to disabled channels
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
endmodule

// File: tb/tb_demux_1x4_stream.sv
// tb_demux_1x4_stream: randomized and directed scoreboard bench for the stream demultiplexer
module tb_demux_1x4_stream;
  localparam int DW = 8;
  localparam int CW = 8;
  logic clk = 0;
  logic rst_n = 0;
  logic in_valid = 0;
  logic in_ready;
  logic [1:0] in_sel = 0;
  logic [DW-1:0] in_data = 0;
  logic [3:0] chan_en = 0;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 0;
  logic [4*DW-1:0] out_data;
  logic [CW-1:0] drop_cnt;
  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  bit run = 0;
  logic [DW-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [DW-1:0] rd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  demux_1x4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .chan_en(chan_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : k == 2 ? q2.size() : q3.size();
  endfunction

  function automatic logic [DW-1:0] qfront(int k);
    return k == 0 ? q0[0] : k == 1 ? q1[0] : k == 2 ? q2[0] : q3[0];
  endfunction

  task automatic qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else if (k == 1) void'(q1.pop_front());
    else if (k == 2) void'(q2.pop_front());
    else void'(q3.pop_front());
  endtask

  task automatic qpush(int k, logic [DW-1:0] d);
    if (k == 0) q0.push_back(d);
    else if (k == 1) q1.push_back(d);
    else if (k == 2) q2.push_back(d);
    else q3.push_back(d);
  endtask

  task automatic clear_model();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    exp_drop = 0;
  endtask

  // monitor and scoreboard: checks outputs against pending beats, then applies this cycle's transfers
  always @(negedge clk) begin
    if (run && rst_n) begin
      bit rdy;
      int s;
      s = int'(in_sel);
      rdy = !chan_en[in_sel] || qsize(s) == 0 || out_ready[in_sel];
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid%0d", k), 64'(out_valid[k]), 64'(qsize(k) != 0));
        if (qsize(k) != 0) begin
          chk($sformatf("out_data%0d", k), 64'(out_data[k*DW +: DW]), 64'(qfront(k)));
          if (out_ready[k]) qpop(k);
        end
      end
      if (in_valid && rdy) begin
        if (chan_en[in_sel]) qpush(s, in_data);
        else if (exp_drop < 255) exp_drop++;
      end
    end
  end

  task automatic cyc(bit v, logic [1:0] s, logic [DW-1:0] d, logic [3:0] en, logic [3:0] r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sel = s;
    in_data = d;
    chan_en = en;
    out_ready = r;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    run = 1;
    // reset while ch2 is stalled holding 0xA5
    cyc(1, 2, 8'hA5, 4'hF, 4'h0);
    cyc(0, 0, 8'h00, 4'hF, 4'h0);
    cyc(0, 0, 8'h00, 4'hF, 4'h0);
    @(posedge clk);
    #2;
    chk("stall_held", 64'(out_data[2*DW +: DW]), 64'hA5);
    rst_n = 0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_out_data", 64'(out_data), 64'd0);
    chk("async_drop_cnt", 64'(drop_cnt), 64'd0);
    clear_model();
    rst_n = 1;
    // routing to each channel
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), rd[i], 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    // backpressure on ch1
    cyc(1, 1, 8'h5A, 4'hF, 4'b1101);
    cyc(1, 1, 8'h6B, 4'hF, 4'b1101);
    cyc(1, 1, 8'h6B, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    // full rate on ch3
    for (int i = 0; i < 8; i++) cyc(1, 3, 8'hC0 + 8'(i), 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    // disable ch2 while it holds a beat
    cyc(1, 2, 8'h77, 4'hF, 4'b1011);
    cyc(1, 2, 8'h88, 4'b1011, 4'b1011);
    cyc(0, 0, 8'h00, 4'b1011, 4'b1011);
    cyc(0, 0, 8'h00, 4'b1011, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
          $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF, 4'($urandom));
    // drop counter saturation from a fresh reset
    @(posedge clk);
    #1;
    in_valid = 0;
    rst_n = 0;
    clear_model();
    #1;
    rst_n = 1;
    for (int i = 0; i < 300; i++) cyc(1, 0, 8'($urandom), 4'b1110, 4'hF);
    cyc(0, 0, 8'h00, 4'hF, 4'hF);
    @(negedge clk);
    #1;
    chk("drop_saturated", 64'(drop_cnt), 64'd255);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- 1-to-4 stream demultiplexer: the inverse of the 4:1 select path. One valid/ready input stream is steered to one of four output channels by a 2-bit select.
- A 2:4 enabled decoder drives the per-channel load enables.
- Each output channel has a one-entry registered holding stage, so source and sinks are decoupled and stall independently.
- Beats addressed to a disabled channel are dropped and counted.

Parameters:
- DATA_W, 8, payload width per beat.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  source beat present.
- in_ready  output  1  block accepts beat this cycle (combinational).
- in_sel  input  2  destination channel index 0..3.
- in_data  input  DATA_W  source payload.
- chan_en  input  4  per-channel enable mask; bit k=1 means channel k is live.
- out_valid  output  4  bit k: channel k holds a beat.
- out_ready  input  4  bit k: sink k accepts this cycle.
- out_data  output  4*DATA_W  channel k payload at [k*DATA_W +: DATA_W].
- drop_cnt  output  CNT_W  count of beats dropped to disabled channels.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-transfer): out_valid=0, out_data=0, drop_cnt=0 immediately. In-flight held beats are discarded. in_ready follows the combinational rule below from the reset state.
- Decode: dec[k] = (in_sel==k) & in_valid.
- in_ready:
  - chan_en[in_sel]=0: 1 (drop path always accepts).
  - Otherwise: ~out_valid[in_sel] | out_ready[in_sel]. This is pass-through ready, so a full slot being drained this cycle still accepts.
- Accept = in_valid & in_ready.
- Accept to an enabled channel k: next edge out_data[k] <= in_data, out_valid[k] <= 1. Latency is 1 cycle from acceptance to out_valid.
- Accept to a disabled channel: no channel state changes. drop_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- Channel k drain: out_valid[k] & out_ready[k] with no load to k in the same cycle clears out_valid[k] next edge. out_data[k] holds its last value and is not cleared.
- Simultaneous drain and load on the same channel: out_valid[k] stays 1 and out_data[k] takes the new beat. This gives a full rate of 1 beat/cycle per channel when out_ready[k]=1.
- Stall: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is stable and out_valid[k] cannot deassert.
- Channels not addressed this cycle are unaffected. Different channels drain independently and in the same cycle.
- chan_en[k] dropping to 0 while channel k holds a beat: the held beat is still delivered normally. Only new beats are dropped.
- in_valid=0: in_sel, in_data and chan_en are don't-care, and no state changes except drains.
- Only one channel can load per cycle; there is no internal arbitration.

Decomposition:
- Shared package: DATA_W and CNT_W defaults, the NUM_CH=4 constant, and the SEL_W=2 constant.
- Sub-module dec_2x4_en: a 2:4 one-hot decoder with enable (en=in_valid). It is instantiated once to produce the per-channel load strobes.
- The holding-register/valid logic is written as a generate loop over the 4 channels, not as a separate module.

Test Plan:
- Reset mid-stall: load ch2 with 0xA5, hold out_ready=0, pulse rst_n low -> out_valid=4'b0000, out_data=0, drop_cnt=0 asynchronously, before the next clk edge.
- Routing: chan_en=4'hF, out_ready=4'hF, send in_sel=0..3 with data 0x11,0x22,0x33,0x44 on consecutive cycles -> each out_valid[k] is high exactly 1 cycle after its beat, with out_data[k] = 0x11,0x22,0x33,0x44 respectively.
- Backpressure: out_ready[1]=0, send 0x5A to ch1 and then 0x6B to ch1:
  - in_ready=0 on the second beat; out_data[1] stays 0x5A.
  - Raise out_ready[1] -> second beat accepted that cycle, out_data[1]=0x6B next edge, out_valid[1] stays 1.
- Full throughput: out_ready[3]=1, 8 back-to-back beats to ch3 -> in_ready stays 1, 8 beats delivered in order on 8 consecutive cycles.
- Drop and saturation: chan_en=4'b1110, CNT_W=8, send 300 beats with in_sel=0:
  - in_ready=1 throughout; out_valid[0] never asserts.
  - drop_cnt=255 at the end.
- Disable with pending beat: ch2 holds 0x77 with out_ready[2]=0, clear chan_en[2], send 0x88 to ch2 -> drop_cnt +1. Then raise out_ready[2] -> 0x77 delivered once and out_valid[2] clears.
